// File: rtl/flash_seq_pkg.sv
// flash_seq_pkg: opcodes, request/state enums and the drive-field bank type for the flash sequencer
package flash_seq_pkg;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_PROG  = 8'h02;
  localparam logic [7:0] CMD_ERASE = 8'h20;
  localparam logic [7:0] CMD_WREN  = 8'h06;
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam logic [1:0] DM_NONE   = 2'b00;
  localparam logic [1:0] DM_SINGLE = 2'b01;
  typedef enum logic [1:0] {OP_READ = 2'b00, OP_PROG = 2'b01, OP_ERASE = 2'b10, OP_RSVD = 2'b11} req_op_e;
  typedef enum logic [3:0] {IDLE, WREN, WREN_WAIT, OP, OP_WAIT, POLL, POLL_WAIT, POLL_RX, DONE} state_e;
  typedef struct packed {
    logic [7:0]  cmd;
    logic [1:0]  data_mode;
    logic        rd_wr;
    logic [7:0]  data_count;
    logic        has_addr;
    logic [23:0] addr;
  } drive_t;
  localparam drive_t WREN_DRV = '{cmd: CMD_WREN, data_mode: DM_NONE, rd_wr: 1'b0, data_count: 8'd0, has_addr: 1'b0, addr: 24'd0};
  localparam drive_t POLL_DRV = '{cmd: CMD_RDSR, data_mode: DM_SINGLE, rd_wr: 1'b1, data_count: 8'd0, has_addr: 1'b0, addr: 24'd0};
  function automatic drive_t op_drive(req_op_e op, logic [23:0] addr, logic [7:0] len);
    return '{cmd: op == OP_READ ? CMD_READ : op == OP_PROG ? CMD_PROG : CMD_ERASE,
             data_mode: op == OP_ERASE ? DM_NONE : DM_SINGLE,
             rd_wr: op == OP_READ,
             data_count: op == OP_ERASE ? 8'd0 : len,
             has_addr: 1'b1,
             addr: addr};
  endfunction
endpackage

// File: rtl/flash_cmd_sequencer_if.sv
// flash_cmd_sequencer_if: request handshake and completion status of the flash sequencer
interface flash_cmd_sequencer_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [23:0] req_addr_i;
  logic [7:0]  req_len_i;
  logic        done_o;
  logic        err_o;
  logic        busy_o;
  modport slave (input req_valid_i, req_op_i, req_addr_i, req_len_i, output req_ready_o, done_o, err_o, busy_o);
  modport master (output req_valid_i, req_op_i, req_addr_i, req_len_i, input req_ready_o, done_o, err_o, busy_o);
endinterface

// File: rtl/flash_cmd_sequencer.sv
// flash_cmd_sequencer: turns read/program/erase requests into SPI wrapper commands with WREN and WIP polling
module flash_cmd_sequencer
  import flash_seq_pkg::*;
#(
  parameter logic [23:0] POLL_TIMEOUT = 24'd1_000_000,
  parameter logic [5:0]  PRESCALER    = 6'd2
) (
  input  logic                    clk,
  input  logic                    rstn,
  flash_cmd_sequencer_if.slave    req,
  output logic [7:0]              command_o,
  output logic [1:0]              data_mode_o,
  output logic                    rd_wr_o,
  output logic [4:0]              dummy_cycle_o,
  output logic [7:0]              data_count_o,
  output logic                    has_addr_o,
  output logic [23:0]             addr_o,
  output logic [5:0]              prescaler_o,
  output logic                    start_o,
  output logic                    clr_status_o,
  input  logic                    status_i,
  input  logic [31:0]             data_rx_i,
  input  logic                    data_rx_valid_i,
  output logic                    data_rx_ready_o
);
  state_e      state_q, state_d;
  req_op_e     op_q, op_d;
  logic [23:0] addr_q, addr_d, timer_q, timer_d;
  logic [7:0]  len_q, len_d;
  drive_t      drv_q, drv_d;
  logic        start_q, done_q, err_q, err_d, rx_ready_q;
  logic        issue_d, timeout, page_cross, unused_rx;

  assign timeout    = {1'b0, timer_q} + 25'd1 >= {1'b0, POLL_TIMEOUT};
  assign page_cross = {1'b0, req.req_addr_i[7:0]} + {1'b0, req.req_len_i} > 9'd255;
  assign issue_d    = state_d inside {WREN, OP, POLL};
  assign unused_rx  = ^data_rx_i[31:1];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    len_d   = len_q;
    timer_d = timer_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (req.req_valid_i) begin
        op_d   = req_op_e'(req.req_op_i);
        addr_d = req.req_addr_i;
        len_d  = req.req_len_i;
        err_d  = op_d == OP_RSVD || (op_d == OP_PROG && page_cross);
        state_d = err_d ? DONE : op_d == OP_READ ? OP : WREN;
      end
      WREN:      state_d = WREN_WAIT;
      WREN_WAIT: if (status_i) state_d = OP;
      OP:        state_d = OP_WAIT;
      OP_WAIT: if (status_i) begin
        state_d = op_q == OP_READ ? DONE : POLL;
        timer_d = '0;
      end
      POLL:      state_d = POLL_WAIT;
      POLL_WAIT: if (status_i) state_d = POLL_RX;
      POLL_RX:   if (data_rx_valid_i) state_d = data_rx_i[0] ? POLL : DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    // timeout overrides whatever poll sub-state we are in
    if (state_q inside {POLL, POLL_WAIT, POLL_RX}) begin
      timer_d = timer_q + 24'd1;
      if (timeout) begin
        state_d = DONE;
        err_d   = 1'b1;
      end
    end
    drv_d = state_d == WREN ? WREN_DRV : state_d == OP ? op_drive(op_d, addr_d, len_d) : state_d == POLL ? POLL_DRV : drv_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      op_q       <= OP_READ;
      addr_q     <= '0;
      len_q      <= '0;
      timer_q    <= '0;
      drv_q      <= '0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      timer_q    <= timer_d;
      drv_q      <= drv_d;
      start_q    <= issue_d;
      done_q     <= state_d == DONE;
      err_q      <= err_d;
      rx_ready_q <= state_d == POLL_RX;
    end
  end

  assign req.req_ready_o = state_q == IDLE;
  assign req.busy_o      = state_q != IDLE;
  assign req.done_o      = done_q;
  assign req.err_o       = err_q;
  assign command_o       = drv_q.cmd;
  assign data_mode_o     = drv_q.data_mode;
  assign rd_wr_o         = drv_q.rd_wr;
  assign data_count_o    = drv_q.data_count;
  assign has_addr_o      = drv_q.has_addr;
  assign addr_o          = drv_q.addr;
  assign dummy_cycle_o   = '0;
  assign prescaler_o     = PRESCALER;
  assign start_o         = start_q;
  assign clr_status_o    = start_q;
  assign data_rx_ready_o = rx_ready_q;
endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// tb_flash_cmd_sequencer: vector table plus hand sequences against a small SPI-wrapper/flash model
module tb_flash_cmd_sequencer;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  flash_cmd_sequencer_if rq();
  logic [7:0]  command_o, data_count_o;
  logic [1:0]  data_mode_o;
  logic        rd_wr_o, has_addr_o, start_o, clr_status_o, data_rx_ready_o;
  logic [4:0]  dummy_cycle_o;
  logic [23:0] addr_o;
  logic [5:0]  prescaler_o;
  logic        status_i = 1'b0;
  logic [31:0] data_rx_i = 32'd0;
  logic        data_rx_valid_i = 1'b0;
  logic [43:0] drv;
  assign drv = {command_o, data_mode_o, rd_wr_o, data_count_o, has_addr_o, addr_o};

  flash_cmd_sequencer #(.POLL_TIMEOUT(24'd100), .PRESCALER(6'd2)) dut (
    .clk(clk), .rstn(rstn), .req(rq),
    .command_o(command_o), .data_mode_o(data_mode_o), .rd_wr_o(rd_wr_o), .dummy_cycle_o(dummy_cycle_o),
    .data_count_o(data_count_o), .has_addr_o(has_addr_o), .addr_o(addr_o), .prescaler_o(prescaler_o),
    .start_o(start_o), .clr_status_o(clr_status_o), .status_i(status_i), .data_rx_i(data_rx_i),
    .data_rx_valid_i(data_rx_valid_i), .data_rx_ready_o(data_rx_ready_o)
  );

  int total = 0, bad = 0;
  int cnt = 0, n_starts = 0, n_done = 0, polls = 0, cyc = 0, first_poll = 0, done_cyc = 0;
  int stab_err = 0, pair_err = 0, rxr_err = 0, wip_ones = 0;
  logic wip_stuck = 1'b0, take = 1'b0;
  logic [7:0] cur = 8'd0;
  logic [43:0] prev_drv = '0;
  logic [7:0]  log_cmd[256], log_cnt[256];
  logic [23:0] log_addr[256];
  logic [1:0]  log_dm[256];
  logic        log_ha[256], log_rw[256];

  // flash model: 3-cycle transfers, status latch, RDSR returns WIP through the RX handshake
  always @(negedge clk) begin
    if (!rstn) begin
      status_i = 1'b0; cnt = 0; data_rx_valid_i = 1'b0; take = 1'b0; cur = 8'd0; prev_drv = drv;
    end else begin
      cyc++;
      if (take) begin data_rx_valid_i = 1'b0; take = 1'b0; end
      else if (data_rx_valid_i && data_rx_ready_o) take = 1'b1;
      if (start_o != clr_status_o || (rq.err_o && !rq.done_o)) pair_err++;
      if (!start_o && drv != prev_drv) stab_err++;
      prev_drv = drv;
      if (data_rx_ready_o && cur != 8'h05) rxr_err++;
      if (rq.done_o) begin n_done++; done_cyc = cyc; end
      if (start_o) begin
        status_i = 1'b0; cnt = 3; cur = command_o;
        if (cur == 8'h06) polls = 0;
        if (cur == 8'h05 && polls == 0) first_poll = cyc;
        if (n_starts < 256) begin
          log_cmd[n_starts] = command_o; log_cnt[n_starts] = data_count_o; log_addr[n_starts] = addr_o;
          log_dm[n_starts] = data_mode_o; log_ha[n_starts] = has_addr_o; log_rw[n_starts] = rd_wr_o;
        end
        n_starts++;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          status_i = 1'b1;
          if (cur == 8'h05) begin
            data_rx_i = {31'd0, wip_stuck || polls < wip_ones};
            data_rx_valid_i = 1'b1;
            polls++;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic [1:0] op, input logic [23:0] addr, input logic [7:0] len,
                         output logic got, output logic e, output logic d2);
    int k = 0;
    while (!rq.req_ready_o && k < 100) begin @(negedge clk); k++; end
    rq.req_op_i = op; rq.req_addr_i = addr; rq.req_len_i = len; rq.req_valid_i = 1'b1;
    got = 1'b0; e = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      rq.req_valid_i = 1'b0;
      if (rq.done_o) begin got = 1'b1; e = rq.err_o; end
    end
    if (!got) $display("FAIL req_timeout: no done_o for op %0d", op);
    @(negedge clk);
    d2 = rq.done_o;
  endtask

  typedef struct {
    logic [1:0]      op;
    logic [23:0]     addr;
    logic [7:0]      len;
    int              wip;
    logic            exp_err;
    int              exp_n;
    logic [4:0][7:0] cmds;
    int              op_idx;
    logic [7:0]      exp_cnt;
    logic [1:0]      exp_dm;
    logic            exp_rw;
  } vec_t;
  vec_t tv[7];

  initial begin
    logic got, e, d2;
    int base, j, d0, acc, dbl, dt;
    logic prev_r;
    rq.req_valid_i = 1'b0; rq.req_op_i = 2'b00; rq.req_addr_i = 24'd0; rq.req_len_i = 8'd0;
    tv[0] = '{2'b00, 24'h001000, 8'd3,   0, 1'b0, 1, {8'h03, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 8'd3,   2'b01, 1'b1};
    tv[1] = '{2'b01, 24'h000010, 8'd15,  2, 1'b0, 5, {8'h06, 8'h02, 8'h05, 8'h05, 8'h05}, 1, 8'd15,  2'b01, 1'b0};
    tv[2] = '{2'b10, 24'h020000, 8'd7,   0, 1'b0, 3, {8'h06, 8'h20, 8'h05, 8'h00, 8'h00}, 1, 8'd0,   2'b00, 1'b0};
    tv[3] = '{2'b01, 24'h0000F0, 8'd31,  0, 1'b1, 0, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 8'd0,   2'b00, 1'b0};
    tv[4] = '{2'b11, 24'h000000, 8'd0,   0, 1'b1, 0, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 8'd0,   2'b00, 1'b0};
    tv[5] = '{2'b01, 24'h0000F0, 8'd15,  1, 1'b0, 4, {8'h06, 8'h02, 8'h05, 8'h05, 8'h00}, 1, 8'd15,  2'b01, 1'b0};
    tv[6] = '{2'b00, 24'hABCDEF, 8'hFF,  0, 1'b0, 1, {8'h03, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 8'hFF,  2'b01, 1'b1};

    @(negedge clk); @(negedge clk);
    chk("reset_outs", {start_o, clr_status_o, rq.done_o, rq.err_o, rq.busy_o, data_rx_ready_o, drv}, '0);
    rstn = 1'b1;
    @(negedge clk);
    chk("reset_ready", {rq.req_ready_o, rq.busy_o}, 2'b10);
    chk("prescaler", prescaler_o, 6'd2);
    chk("dummy", dummy_cycle_o, 5'd0);

    for (int v = 0; v < 7; v++) begin
      wip_ones = tv[v].wip;
      base = n_starts;
      run_req(tv[v].op, tv[v].addr, tv[v].len, got, e, d2);
      chk($sformatf("v%0d done", v), got, 1'b1);
      chk($sformatf("v%0d err", v), e, tv[v].exp_err);
      chk($sformatf("v%0d done_width", v), d2, 1'b0);
      chk($sformatf("v%0d n_starts", v), n_starts - base, tv[v].exp_n);
      for (int i = 0; i < tv[v].exp_n; i++) chk($sformatf("v%0d cmd%0d", v, i), log_cmd[base + i], tv[v].cmds[4 - i]);
      if (tv[v].exp_n > 0) begin
        j = base + tv[v].op_idx;
        chk($sformatf("v%0d op_cnt", v), log_cnt[j], tv[v].exp_cnt);
        chk($sformatf("v%0d op_addr", v), log_addr[j], tv[v].addr);
        chk($sformatf("v%0d op_dm_rw_ha", v), {log_dm[j], log_rw[j], log_ha[j]}, {tv[v].exp_dm, tv[v].exp_rw, 1'b1});
      end
      if (tv[v].exp_n > 1) chk($sformatf("v%0d wren_fields", v), {log_ha[base], log_addr[base], log_cnt[base]}, '0);
    end

    // erase with WIP stuck: poll timer must end it after POLL_TIMEOUT poll cycles
    wip_stuck = 1'b1;
    run_req(2'b10, 24'h020000, 8'd0, got, e, d2);
    dt = done_cyc - first_poll;
    chk("timeout_done", got, 1'b1);
    chk("timeout_err", e, 1'b1);
    chk("timeout_cycles_ok", dt >= 100 && dt <= 101, 1'b1);
    wip_stuck = 1'b0;

    // reset during OP_WAIT of a program
    wip_ones = 0;
    base = n_starts;
    rq.req_op_i = 2'b01; rq.req_addr_i = 24'h000010; rq.req_len_i = 8'd15; rq.req_valid_i = 1'b1;
    @(negedge clk);
    rq.req_valid_i = 1'b0;
    for (int k = 0; k < 100 && n_starts < base + 2; k++) @(negedge clk);
    chk("rst_mid_reached_op", log_cmd[base + 1], 8'h02);
    @(negedge clk);
    d0 = n_done;
    rstn = 1'b0;
    #1;
    chk("rst_mid_outs", {start_o, clr_status_o, rq.done_o, rq.err_o, rq.busy_o, data_rx_ready_o, drv}, '0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", {rq.req_ready_o, rq.busy_o}, 2'b10);
    repeat (5) @(negedge clk);
    chk("rst_mid_no_done", n_done - d0, 0);
    run_req(2'b00, 24'h000040, 8'd7, got, e, d2);
    chk("post_rst_read", {got, e}, 2'b10);

    // valid held high through busy sequences: one acceptance per IDLE visit
    d0 = n_done; acc = 0; dbl = 0; prev_r = 1'b0;
    rq.req_op_i = 2'b00; rq.req_addr_i = 24'h000200; rq.req_len_i = 8'd1; rq.req_valid_i = 1'b1;
    for (int k = 0; k < 80; k++) begin
      if (rq.req_ready_o) acc++;
      if (rq.req_ready_o && prev_r) dbl++;
      prev_r = rq.req_ready_o;
      @(negedge clk);
    end
    rq.req_valid_i = 1'b0;
    for (int k = 0; k < 100 && rq.busy_o; k++) @(negedge clk);
    @(negedge clk);
    chk("held_acc_min", acc >= 3, 1'b1);
    chk("held_one_done_per_acc", n_done - d0, acc);
    chk("held_no_double", dbl, 0);

    chk("start_clr_pair_err_only_with_done", pair_err, 0);
    chk("drive_stable", stab_err, 0);
    chk("rx_ready_only_poll", rxr_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
